anthem_stream_checker: RTL and testbench
========================================

# anthem_stream_checker

Receive-side checker for the anthem byte stream. It samples the 8-bit ASCII stream produced by the on-chip transmitter, one byte per enabled cycle, and aligns to frame boundaries. It compares every byte against the same 11-byte frame pattern "Tajumulco T" and reports lock, per-frame pass and mismatch events, and running counts. It sits on the loopback or external-input path (uo_out wired back to the data input) as the self-test partner of the transmitter.

## Interface
- `LEN`, default 11: frame length in bytes. Must be 2..16 and match the pattern ROM length.
- `LOCK_FRAMES`, default 2: consecutive good frames required to assert `locked`. Range 1..15.
- `clk`  input  1  clock.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `in_valid`  input  1  byte qualifier. `in_byte` is sampled only on edges where this is high.
- `in_byte`  input  8  received byte.
- `clr`  input  1  synchronous clear of `good_cnt`/`err_cnt`. Lock state is unaffected.
- `locked`  output  1  level, stream aligned and verified.
- `frame_ok`  output  1  one-cycle pulse when a complete frame matched.
- `err`  output  1  one-cycle pulse on a byte mismatch while aligned (CHECK or LOCKED).
- `pos`  output  4  index of the next expected byte (0 in HUNT).
- `good_cnt`  output  8  saturating count of matched frames.
- `err_cnt`  output  8  saturating mismatch count (see Configuration).

## Operation
- Pattern ROM, index 0..10: 54 61 6A 75 6D 75 6C 63 6F 20 54 (hex).
- FSM states are HUNT, CHECK and LOCKED. Reset state is HUNT, with `pos`=0 and consecutive-good counter `run`=0.
- HUNT:
  - Accepted byte == 0x54: go to CHECK, `pos`=1.
  - Any other byte: stay in HUNT, no `err`.
- CHECK/LOCKED, accepted byte == ROM[`pos`]:
  - If `pos` < LEN-1: `pos`+1.
  - If `pos` == LEN-1: pulse `frame_ok`, `pos`=0, `good_cnt`+1 (saturates at 255), `run`+1 (saturates at LOCK_FRAMES).
  - When `run` reaches LOCK_FRAMES, enter LOCKED.
- CHECK/LOCKED, mismatch: pulse `err`, `err_cnt`+1, `run`=0, `locked` deasserts. Then:
  - Mismatching byte == 0x54 (resync): go to CHECK, `pos`=1.
  - Otherwise: go to HUNT, `pos`=0.
- Frame boundary: the stream contains "...6F 20 54 54 61...". Byte 10 (0x54) completes a frame. The next 0x54 is matched as ROM[0] at `pos`=0, so a continuous stream never errors.
- A cycle with `in_valid`=0 holds all state. Pulses are not generated on that cycle.
- `clr` zeroes both counters on the next edge. If a count event coincides with `clr`, `clr` wins and the result is 0.
- Reset mid-frame immediately returns to HUNT. All outputs go to 0.

## Timing
- All outputs are registered. They update on the same edge that accepts the byte, so there is zero added latency.
- `frame_ok` is high for exactly the one cycle after the edge that accepted byte LEN-1.
- `err` is high for exactly the one cycle after the edge that accepted the mismatching byte.
- `locked` rises on the edge that completes the LOCK_FRAMES-th consecutive good frame, together with that `frame_ok`. It falls on the edge accepting a mismatch, together with `err`.
- From reset, an aligned stream starting with 0x54 locks after 2×LEN = 22 accepted bytes (LOCK_FRAMES=2).
- Reset values: `locked`=0, `frame_ok`=0, `err`=0, `pos`=0, `good_cnt`=0, `err_cnt`=0.

## Configuration
- `CHECKER_ERRCNT_EN` defined: the 8-bit saturating `err_cnt` register is implemented and cleared by `clr`/reset.
- `CHECKER_ERRCNT_EN` undefined: no counter register; `err_cnt` is tied to 8'h00. `err` pulses behave identically in both builds.

## Test plan
- Reset, then a continuous stream of 00 followed by 3 frames (33 bytes): `frame_ok` pulses after bytes 11/22/33; `locked`=1 from byte 22; `good_cnt`=3; `err` never asserts.
- While locked, replace byte 4 (0x6D) with 0x00: `err` pulse, `locked`=0, `pos`=0 (HUNT), `err_cnt`=1. The next frame restores CHECK; `locked` returns after 2 good frames.
- While in CHECK at `pos`=3, feed 0x54: `err` pulse, `pos`=1. Following bytes 61 6A ... 54 give `frame_ok`.
- Aligned stream with `in_valid` toggling 1/0 every cycle: same `frame_ok` count as the continuous stream; no pulses on invalid cycles.
- Drive 300 good frames: `good_cnt` saturates at 255. Assert `clr` on the same edge as a `frame_ok`: `good_cnt`=0 afterwards.
- Assert `rst_n`=0 mid-frame at `pos`=6: all outputs go to 0 asynchronously. After release, a fresh frame is required before `frame_ok`.

Source files
------------

// File: rtl/anthem_stream_checker.sv
// anthem_stream_checker: receive-side frame checker for the anthem byte stream.
// Aligns to the 11-byte pattern "Tajumulco T". It reports lock, per-frame pass,
// mismatch pulses and saturating counts.
// Optional build macro: CHECKER_ERRCNT_EN implements the err_cnt register.
// If the macro is undefined, err_cnt is tied to zero.
//
// state  | meaning
// -------+-----------------------------------------------------------
// HUNT   | searching for the first pattern byte (0x54), pos held at 0
// CHECK  | aligned, comparing bytes, fewer than LOCK_FRAMES good frames
// LOCKED | aligned with LOCK_FRAMES consecutive good frames
module anthem_stream_checker #(
    parameter int unsigned LEN         = 11,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    input  logic       clr,
    output logic       locked,
    output logic       frame_ok,
    output logic       err,
    output logic [3:0] pos,
    output logic [7:0] good_cnt,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

    localparam logic [3:0] LAST_POS = 4'(LEN - 1);
    localparam logic [3:0] RUN_MAX  = 4'(LOCK_FRAMES);

    state_t     state_q, state_d;
    logic [3:0] pos_q, pos_d;
    logic [3:0] run_q, run_d;
    logic       frame_ok_d, err_d;
    logic       good_inc, err_inc;
    logic [7:0] exp_byte;

    function automatic logic [7:0] rom_byte(input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = 8'h54;
            4'd1:    b = 8'h61;
            4'd2:    b = 8'h6A;
            4'd3:    b = 8'h75;
            4'd4:    b = 8'h6D;
            4'd5:    b = 8'h75;
            4'd6:    b = 8'h6C;
            4'd7:    b = 8'h63;
            4'd8:    b = 8'h6F;
            4'd9:    b = 8'h20;
            4'd10:   b = 8'h54;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign exp_byte = rom_byte(pos_q);

    // Next-state and pulse decode; nothing changes on cycles without in_valid.
    always_comb begin
        logic [3:0] run_inc;
        state_d    = state_q;
        pos_d      = pos_q;
        run_d      = run_q;
        frame_ok_d = 1'b0;
        err_d      = 1'b0;
        good_inc   = 1'b0;
        err_inc    = 1'b0;
        run_inc    = (run_q < RUN_MAX) ? run_q + 4'd1 : run_q;
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (in_byte == rom_byte(4'd0)) begin
                        state_d = CHECK;
                        pos_d   = 4'd1;
                    end
                end
                CHECK, LOCKED: begin
                    if (in_byte == exp_byte) begin
                        if (pos_q == LAST_POS) begin
                            frame_ok_d = 1'b1;
                            good_inc   = 1'b1;
                            pos_d      = 4'd0;
                            run_d      = run_inc;
                            if (run_inc == RUN_MAX)
                                state_d = LOCKED;
                        end else begin
                            pos_d = pos_q + 4'd1;
                        end
                    end else begin
                        err_d   = 1'b1;
                        err_inc = 1'b1;
                        run_d   = 4'd0;
                        // A mismatching 0x54 may be the start of a new frame.
                        if (in_byte == rom_byte(4'd0)) begin
                            state_d = CHECK;
                            pos_d   = 4'd1;
                        end else begin
                            state_d = HUNT;
                            pos_d   = 4'd0;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    pos_d   = 4'd0;
                    run_d   = 4'd0;
                end
            endcase
        end
    end

    // FSM state, position, run length and output pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            pos_q    <= 4'd0;
            run_q    <= 4'd0;
            frame_ok <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            run_q    <= run_d;
            frame_ok <= frame_ok_d;
            err      <= err_d;
        end
    end

    // Saturating good-frame counter; clr takes priority over a coincident count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            good_cnt <= 8'd0;
        else if (clr)
            good_cnt <= 8'd0;
        else if (good_inc && good_cnt != 8'hFF)
            good_cnt <= good_cnt + 8'd1;
    end

`ifdef CHECKER_ERRCNT_EN
    // Saturating mismatch counter; clr takes priority over a coincident count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= 8'd0;
        else if (clr)
            err_cnt <= 8'd0;
        else if (err_inc && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end
`else
    assign err_cnt = 8'h00;
    logic unused_err_inc;
    assign unused_err_inc = err_inc;
`endif

    assign locked = (state_q == LOCKED);
    assign pos    = pos_q;

endmodule

// File: tb/tb_anthem_stream_checker.sv
// Bench for anthem_stream_checker. A behavioural model of the frame checker
// pushes the expected outputs for every driven cycle into a queue. Each entry
// is popped and compared one time unit after the clock edge.
module tb_anthem_stream_checker;

    localparam int LEN  = 11;
    localparam int LOCK = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       clr = 1'b0;
    logic       locked, frame_ok, err;
    logic [3:0] pos;
    logic [7:0] good_cnt, err_cnt;

    typedef struct packed {
        logic       locked;
        logic       frame_ok;
        logic       err;
        logic [3:0] pos;
        logic [7:0] good;
        logic [7:0] errc;
    } exp_t;

    exp_t sb_q[$];

    logic [7:0] pat [0:10] = '{8'h54, 8'h61, 8'h6A, 8'h75, 8'h6D, 8'h75,
                              8'h6C, 8'h63, 8'h6F, 8'h20, 8'h54};

    int m_st, m_pos, m_run, m_good, m_errc;
    int n_checks = 0;
    int n_errors = 0;
    int fo_count = 0;
    int err_count = 0;

    anthem_stream_checker #(.LEN(LEN), .LOCK_FRAMES(LOCK)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_byte(in_byte),
        .clr(clr), .locked(locked), .frame_ok(frame_ok), .err(err),
        .pos(pos), .good_cnt(good_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_pos = 0; m_run = 0; m_good = 0; m_errc = 0;
    endtask

    // Drive one cycle, predict its outputs, then compare after the edge.
    task automatic drive(input logic v, input logic [7:0] b, input logic c);
        exp_t e, o;
        logic fo, er;
        fo = 1'b0;
        er = 1'b0;
        if (v) begin
            if (m_st == 0) begin
                if (b == 8'h54) begin m_st = 1; m_pos = 1; end
            end else if (b == pat[m_pos]) begin
                if (m_pos == LEN - 1) begin
                    fo = 1'b1;
                    m_pos = 0;
                    if (m_good < 255) m_good++;
                    if (m_run < LOCK) m_run++;
                    if (m_run == LOCK) m_st = 2;
                end else begin
                    m_pos++;
                end
            end else begin
                er = 1'b1;
                if (m_errc < 255) m_errc++;
                m_run = 0;
                if (b == 8'h54) begin m_st = 1; m_pos = 1; end
                else begin m_st = 0; m_pos = 0; end
            end
        end
        if (c) begin m_good = 0; m_errc = 0; end
`ifndef CHECKER_ERRCNT_EN
        m_errc = 0;
`endif
        e.locked   = (m_st == 2);
        e.frame_ok = fo;
        e.err      = er;
        e.pos      = 4'(m_pos);
        e.good     = 8'(m_good);
        e.errc     = 8'(m_errc);
        sb_q.push_back(e);

        in_valid = v;
        in_byte  = b;
        clr      = c;
        @(posedge clk);
        #1;
        o = sb_q.pop_front();
        check("locked", 32'(locked), 32'(o.locked));
        check("frame_ok", 32'(frame_ok), 32'(o.frame_ok));
        check("err", 32'(err), 32'(o.err));
        check("pos", 32'(pos), 32'(o.pos));
        check("good_cnt", 32'(good_cnt), 32'(o.good));
        check("err_cnt", 32'(err_cnt), 32'(o.errc));
        if (frame_ok) fo_count++;
        if (err) err_count++;
        in_valid = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic send_frame();
        for (int i = 0; i < LEN; i++) drive(1'b1, pat[i], 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_frame_ok"}, 32'(frame_ok), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_pos"}, 32'(pos), 32'd0);
        check({tag, "_good"}, 32'(good_cnt), 32'd0);
        check({tag, "_errc"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin
        int fo0, er0;
        model_reset();
        #12;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Idle 00 bytes, then three aligned frames.
        for (int i = 0; i < 5; i++) drive(1'b1, 8'h00, 1'b0);
        fo0 = fo_count;
        send_frame();
        check("lock_after_11", 32'(locked), 32'd0);
        send_frame();
        check("lock_after_22", 32'(locked), 32'd1);
        send_frame();
        check("three_frames", 32'(fo_count - fo0), 32'd3);
        check("good3", 32'(good_cnt), 32'd3);
        check("no_err_stream", 32'(err_count), 32'd0);

        // Corrupt byte 4 while locked, then regain lock.
        for (int i = 0; i < 4; i++) drive(1'b1, pat[i], 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        check("corrupt_err", 32'(err), 32'd1);
        check("corrupt_unlock", 32'(locked), 32'd0);
        check("corrupt_pos", 32'(pos), 32'd0);
`ifdef CHECKER_ERRCNT_EN
        check("corrupt_errcnt", 32'(err_cnt), 32'd1);
`else
        check("corrupt_errcnt", 32'(err_cnt), 32'd0);
`endif
        send_frame();
        check("relock_1", 32'(locked), 32'd0);
        send_frame();
        check("relock_2", 32'(locked), 32'd1);

        // Resync: 0x54 arrives where pos=3 expects 0x75.
        for (int i = 0; i < 3; i++) drive(1'b1, pat[i], 1'b0);
        drive(1'b1, 8'h54, 1'b0);
        check("resync_err", 32'(err), 32'd1);
        check("resync_pos", 32'(pos), 32'd1);
        fo0 = fo_count;
        for (int i = 1; i < LEN; i++) drive(1'b1, pat[i], 1'b0);
        check("resync_frame", 32'(fo_count - fo0), 32'd1);

        // in_valid toggling with junk on the invalid cycles.
        fo0 = fo_count;
        er0 = err_count;
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < LEN; i++) begin
                drive(1'b1, pat[i], 1'b0);
                drive(1'b0, 8'($urandom_range(0, 255)), 1'b0);
            end
        check("toggle_frames", 32'(fo_count - fo0), 32'd3);
        check("toggle_no_err", 32'(err_count - er0), 32'd0);

        // Clear while idle, then saturation of good_cnt.
        drive(1'b0, 8'h00, 1'b1);
        check("clr_idle", 32'(good_cnt), 32'd0);
        for (int f = 0; f < 300; f++) send_frame();
        check("good_sat", 32'(good_cnt), 32'd255);
        for (int i = 0; i < LEN - 1; i++) drive(1'b1, pat[i], 1'b0);
        drive(1'b1, pat[LEN-1], 1'b1);
        check("clr_vs_frame_ok", 32'(frame_ok), 32'd1);
        check("clr_wins", 32'(good_cnt), 32'd0);

        // Async reset at pos=6.
        send_frame();
        for (int i = 0; i < 6; i++) drive(1'b1, pat[i], 1'b0);
        check("pre_rst_pos", 32'(pos), 32'd6);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fo0 = fo_count;
        for (int i = 6; i < LEN; i++) drive(1'b1, pat[i], 1'b0);
        check("rst_no_frame", 32'(fo_count - fo0), 32'd0);
        for (int i = 1; i < LEN; i++) drive(1'b1, pat[i], 1'b0);
        check("rst_fresh_frame", 32'(fo_count - fo0), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
